// File: rtl/nibble_change_fifo.sv
// Change-detecting FIFO behind a 4-bit transparent latch: records each distinct
// enabled sample and hands entries to a consumer over a valid/ready handshake.
module nibble_change_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             d_in,
    input  logic                         en,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         clr_ovf,
    output logic [7:0]                   change_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned CC_W  = 8;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] prev_q,       prev_d;
    logic             prev_vld_q,   prev_vld_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic             overflow_q,   overflow_d;
    logic [CC_W-1:0]  change_cnt_q, change_cnt_d;

    logic push_req;
    logic push_ok;
    logic pop;
    logic full;

    // Change detection and handshake qualification
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        pop      = (count_q != '0) && out_ready;
        push_req = en && (!prev_vld_q || (d_in != prev_q));
        push_ok  = push_req && (!full || pop);
    end

    // Next-state for pointers, occupancy and status
    always_comb begin
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        change_cnt_d = change_cnt_q;

        // A dropped value still becomes the new reference for change detection
        if (en) begin
            prev_d     = d_in;
            prev_vld_d = 1'b1;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set dominates clear when a drop coincides with clr_ovf
        overflow_d = (overflow_q && !clr_ovf) || (push_req && !push_ok);

        if (push_req && (change_cnt_q != '1)) begin
            change_cnt_d = change_cnt_q + CC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            change_cnt_q <= '0;
        end else begin
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            change_cnt_q <= change_cnt_d;
        end
    end

    // Storage carries no reset; contents are only observed while out_valid=1
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= d_in;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign change_cnt = change_cnt_q;

endmodule

// File: tb/tb_nibble_change_fifo.sv
// Self-checking bench for nibble_change_fifo: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_nibble_change_fifo;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d_in;
    logic             en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             clr_ovf;
    logic [7:0]       change_cnt;

    int checks = 0;
    int errors = 0;

    nibble_change_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .en         (en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .change_cnt (change_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of recorded values plus last-seen sample
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_prev;
    bit               m_prev_vld;
    bit               m_ovf;
    int               m_cc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_prev     = '0;
            m_prev_vld = 0;
            m_ovf      = 0;
            m_cc       = 0;
        end else begin
            bit pop, req, ok;
            pop = (m_q.size() != 0) && out_ready;
            req = en && (!m_prev_vld || d_in != m_prev);
            ok  = req && (m_q.size() < DEPTH || pop);
            if (pop) void'(m_q.pop_front());
            if (ok) m_q.push_back(d_in);
            m_ovf = (m_ovf && !clr_ovf) || (req && !ok);
            if (req && m_cc < 255) m_cc = m_cc + 1;
            if (en) begin
                m_prev     = d_in;
                m_prev_vld = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("model.count",      int'(count),      m_q.size());
            chk("model.out_valid",  int'(out_valid),  int'(m_q.size() != 0));
            chk("model.overflow",   int'(overflow),   int'(m_ovf));
            chk("model.change_cnt", int'(change_cnt), m_cc);
            if (m_q.size() != 0) chk("model.out_data", int'(out_data), int'(m_q[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        en = 0; out_ready = 0; clr_ovf = 0; d_in = '0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic fill4();
        en = 1; out_ready = 0;
        d_in = 4'h0; tick();
        d_in = 4'hF; tick();
        d_in = 4'hA; tick();
        d_in = 4'h5; tick();
    endtask

    initial begin
        rst_n = 0; en = 0; out_ready = 0; clr_ovf = 0; d_in = '0;
        tick();
        tick();
        chk("rst.count",      int'(count),      0);
        chk("rst.out_valid",  int'(out_valid),  0);
        chk("rst.overflow",   int'(overflow),   0);
        chk("rst.change_cnt", int'(change_cnt), 0);
        rst_n = 1;

        // 1: repeated identical samples record only once
        en = 1; d_in = 4'h0;
        tick(); tick(); tick();
        chk("t1.count",      int'(count),      1);
        chk("t1.out_data",   int'(out_data),   0);
        chk("t1.change_cnt", int'(change_cnt), 1);

        // 2: fill then drain in order
        do_reset();
        fill4();
        chk("t2.count", int'(count), 4);
        en = 0; out_ready = 1;
        chk("t2.pop0", int'(out_data), 4'h0); tick();
        chk("t2.pop1", int'(out_data), 4'hF); tick();
        chk("t2.pop2", int'(out_data), 4'hA); tick();
        chk("t2.pop3", int'(out_data), 4'h5); tick();
        chk("t2.empty", int'(out_valid), 0);

        // 3: drop when full, then clear sticky overflow
        do_reset();
        fill4();
        d_in = 4'h3; tick();
        chk("t3.overflow",   int'(overflow),   1);
        chk("t3.count",      int'(count),      4);
        chk("t3.change_cnt", int'(change_cnt), 5);
        chk("t3.head",       int'(out_data),   4'h0);
        en = 0; clr_ovf = 1; tick();
        clr_ovf = 0;
        chk("t3.clr", int'(overflow), 0);

        // 4: simultaneous push and pop while full
        en = 1; out_ready = 1; d_in = 4'hC; tick();
        chk("t4.count",      int'(count),      4);
        chk("t4.head",       int'(out_data),   4'hF);
        chk("t4.overflow",   int'(overflow),   0);
        chk("t4.change_cnt", int'(change_cnt), 6);
        en = 0;
        chk("t4.d0", int'(out_data), 4'hF); tick();
        chk("t4.d1", int'(out_data), 4'hA); tick();
        chk("t4.d2", int'(out_data), 4'h5); tick();
        chk("t4.tail", int'(out_data), 4'hC); tick();
        chk("t4.empty", int'(out_valid), 0);
        out_ready = 0;

        // 5: disabled sampling ignores d_in and keeps prev
        en = 1; d_in = 4'h0; tick();
        chk("t5.push", int'(change_cnt), 7);
        en = 0; d_in = 4'hF; tick();
        d_in = 4'h0; tick();
        chk("t5.cc_hold", int'(change_cnt), 7);
        en = 1; d_in = 4'h0; tick();
        chk("t5.reen_cc",    int'(change_cnt), 7);
        chk("t5.reen_count", int'(count),      1);
        en = 0;

        // 6: asynchronous reset mid-cycle
        do_reset();
        en = 1;
        d_in = 4'h1; tick();
        d_in = 4'h2; tick();
        d_in = 4'h3; tick();
        en = 0;
        chk("t6.count3", int'(count), 3);
        #1 rst_n = 0;
        #1;
        chk("t6.async_count", int'(count),     0);
        chk("t6.async_valid", int'(out_valid), 0);
        tick();
        rst_n = 1;
        en = 1; d_in = 4'hA; tick();
        chk("t6.count",      int'(count),      1);
        chk("t6.change_cnt", int'(change_cnt), 1);
        chk("t6.out_data",   int'(out_data),   4'hA);
        en = 0;

        // change_cnt saturates at 255
        do_reset();
        en = 1; out_ready = 1;
        for (int i = 0; i < 300; i++) begin
            d_in = (i % 2 == 0) ? 4'h6 : 4'h9;
            tick();
        end
        chk("sat.change_cnt", int'(change_cnt), 255);
        chk("sat.overflow",   int'(overflow),   0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) < 8);
            d_in      = WIDTH'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 4);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1; en = 0; out_ready = 0; clr_ovf = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
